// File: rtl/decode_sequencer.sv
// decode_sequencer: single-slot instruction decoder with return-stall, halt and
// optional illegal-opcode trap sequencing.
// Build option: define DECODE_ILLEGAL_TRAP_EN to trap on illegal opcodes;
// when undefined, illegal opcodes decode as NOP and the trap state is unreachable.
module decode_sequencer #(
    parameter int INSTR_WIDTH      = 32,
    parameter int WEN_BIT          = 21,
    parameter int RET_STALL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   instr_valid,
    output logic                   decode_ready,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic                   irq_ack,
    input  logic                   resume,
    output logic                   ctl_valid,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [1:0]             reg_file_ren,
    output logic [1:0]             reg_file_wen,
    output logic [1:0]             mem_wren,
    output logic                   main_memory_enable,
    output logic                   call_stack_enable,
    output logic                   return_in_pipeline,
    output logic                   stall_fetch,
    output logic                   halt,
    output logic                   illegal_opcode_exception
);

    localparam int CNT_W = $clog2(RET_STALL_CYCLES + 1);

    typedef enum logic [1:0] {StRun, StRetWait, StHalted, StTrap} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       w_op;
    logic             w_wbit;
    logic             w_legal;
    logic [1:0]       w_ren;
    logic [1:0]       w_wen;
    logic [1:0]       w_mw;
    logic             w_mm;
    logic             w_cs;
    logic             w_accept;
    logic             w_trap;

    logic             r_ctl_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [1:0]       r_ren;
    logic [1:0]       r_wen;
    logic [1:0]       r_mw;
    logic             r_mm;
    logic             r_cs;

    assign w_op   = instr_in[7:0];
    assign w_wbit = instr_in[WEN_BIT];

    // Opcode decode into the control word fields
    always_comb begin
        w_legal = 1'b1;
        w_ren   = 2'b00;
        w_wen   = 2'b00;
        w_mw    = 2'b00;
        w_mm    = 1'b0;
        w_cs    = 1'b0;
        case (w_op)
            8'h00, 8'h38, 8'h9C, 8'h1F: ;
            8'h80, 8'h97: begin
                w_ren = 2'b11;
                w_wen = {1'b0, w_wbit};
            end
            8'h8E: begin
                w_ren = 2'b11;
                w_wen = {w_wbit, w_wbit};
            end
            8'h9E: begin
                w_ren = 2'b01;
                w_wen = {w_wbit, w_wbit};
            end
            8'hBC, 8'h9B, 8'hA5: begin
                w_ren = 2'b01;
                w_wen = {1'b0, w_wbit};
            end
            8'hFB: begin
                w_wen = {1'b0, w_wbit};
                w_mm  = 1'b1;
            end
            8'hF8, 8'hF9: w_wen = {1'b0, w_wbit};
            8'hC4: begin
                w_mw = 2'b01;
                w_mm = 1'b1;
            end
            8'h42, 8'h43: w_cs = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // Ready is forced low during reset so fetch never hands over a word then
    assign decode_ready = ~rst & (r_state == StRun) & ~flush & (~r_ctl_valid | ex_ready);
    assign w_accept     = instr_valid & decode_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_exc;

    assign w_trap = w_accept & ~w_legal;

    // One-cycle exception pulse following an illegal accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc <= 1'b0;
        end else begin
            r_exc <= w_trap;
        end
    end

    assign illegal_opcode_exception = r_exc;
`else
    logic w_unused_legal;

    assign w_trap                   = 1'b0;
    assign w_unused_legal           = w_legal;
    assign illegal_opcode_exception = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                if (w_trap) begin
                    w_state_next = StTrap;
                end else if (w_accept && (w_op == 8'h43)) begin
                    w_state_next = StRetWait;
                end else if (w_accept && (w_op == 8'h1F)) begin
                    w_state_next = StHalted;
                end
            end
            // Leave on the edge where the counter steps from 1 to 0
            StRetWait: if (flush || (r_cnt <= CNT_W'(1))) w_state_next = StRun;
            StHalted:  if (resume) w_state_next = StRun;
            StTrap:    if (irq_ack) w_state_next = StRun;
            default:   w_state_next = StRun;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        return_in_pipeline = 1'b0;
        stall_fetch        = 1'b0;
        halt               = 1'b0;
        unique case (r_state)
            StRetWait: begin
                return_in_pipeline = 1'b1;
                stall_fetch        = 1'b1;
            end
            StTrap:   stall_fetch = 1'b1;
            StHalted: halt        = 1'b1;
            default:  ;
        endcase
    end

    // Return-stall down-counter, saturating at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && (w_op == 8'h43)) begin
            r_cnt <= CNT_W'(RET_STALL_CYCLES);
        end else if (r_state == StRetWait) begin
            if (flush) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Control word holding register; flush beats accept, accept beats drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl_valid <= 1'b0;
            r_instr     <= '0;
            r_ren       <= 2'b00;
            r_wen       <= 2'b00;
            r_mw        <= 2'b00;
            r_mm        <= 1'b0;
            r_cs        <= 1'b0;
        end else begin
            if (flush) begin
                r_ctl_valid <= 1'b0;
            end else if (w_accept) begin
                r_ctl_valid <= ~w_trap;
            end else if (ex_ready) begin
                r_ctl_valid <= 1'b0;
            end
            if (w_accept) begin
                r_instr <= instr_in;
                r_ren   <= w_ren;
                r_wen   <= w_wen;
                r_mw    <= w_mw;
                r_mm    <= w_mm;
                r_cs    <= w_cs;
            end
        end
    end

    assign ctl_valid          = r_ctl_valid;
    assign instr_out          = r_instr;
    assign reg_file_ren       = r_ren;
    assign reg_file_wen       = r_wen;
    assign mem_wren           = r_mw;
    assign main_memory_enable = r_mm;
    assign call_stack_enable  = r_cs;

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_decode_sequencer;

    localparam int IW  = 32;
    localparam int WB  = 21;
    localparam int RSC = 3;

    localparam int M_RUN  = 0;
    localparam int M_RET  = 1;
    localparam int M_HALT = 2;
    localparam int M_TRAP = 3;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr_in;
    logic          instr_valid;
    logic          decode_ready;
    logic          ex_ready;
    logic          flush;
    logic          irq_ack;
    logic          resume;
    logic          ctl_valid;
    logic [IW-1:0] instr_out;
    logic [1:0]    reg_file_ren;
    logic [1:0]    reg_file_wen;
    logic [1:0]    mem_wren;
    logic          main_memory_enable;
    logic          call_stack_enable;
    logic          return_in_pipeline;
    logic          stall_fetch;
    logic          halt;
    logic          illegal_opcode_exception;

    always #5 clk = ~clk;

    decode_sequencer #(
        .INSTR_WIDTH      (IW),
        .WEN_BIT          (WB),
        .RET_STALL_CYCLES (RSC)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .instr_in                 (instr_in),
        .instr_valid              (instr_valid),
        .decode_ready             (decode_ready),
        .ex_ready                 (ex_ready),
        .flush                    (flush),
        .irq_ack                  (irq_ack),
        .resume                   (resume),
        .ctl_valid                (ctl_valid),
        .instr_out                (instr_out),
        .reg_file_ren             (reg_file_ren),
        .reg_file_wen             (reg_file_wen),
        .mem_wren                 (mem_wren),
        .main_memory_enable       (main_memory_enable),
        .call_stack_enable        (call_stack_enable),
        .return_in_pipeline       (return_in_pipeline),
        .stall_fetch              (stall_fetch),
        .halt                     (halt),
        .illegal_opcode_exception (illegal_opcode_exception)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_mode;
    int            m_left;
    logic          m_cv;
    logic          m_exc;
    logic [IW-1:0] m_instr;
    logic [1:0]    m_ren;
    logic [1:0]    m_wen;
    logic [1:0]    m_mw;
    logic          m_mm;
    logic          m_cs;

    logic [7:0] ops [17] = '{8'h00, 8'hBC, 8'h80, 8'h8E, 8'h9E, 8'h97, 8'h9B, 8'hA5, 8'hFB,
                             8'hC4, 8'hF8, 8'h9C, 8'h38, 8'h42, 8'h43, 8'hF9, 8'h1F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] op);
        return op inside {8'h00, 8'hBC, 8'h80, 8'h8E, 8'h9E, 8'h97, 8'h9B, 8'hA5, 8'hFB,
                          8'hC4, 8'hF8, 8'h9C, 8'h38, 8'h42, 8'h43, 8'hF9, 8'h1F};
    endfunction

    task automatic ref_decode(input logic [IW-1:0] ins);
        logic [7:0] op;
        logic       b;
        op = ins[7:0];
        b  = ins[WB];
        if (op inside {8'h80, 8'h8E, 8'h97})             m_ren = 2'b11;
        else if (op inside {8'hBC, 8'h9E, 8'h9B, 8'hA5}) m_ren = 2'b01;
        else                                             m_ren = 2'b00;
        m_wen[0] = b & (op inside {8'hBC, 8'h80, 8'h8E, 8'h9E, 8'h97, 8'h9B, 8'hA5,
                                   8'hFB, 8'hF8, 8'hF9});
        m_wen[1] = b & (op inside {8'h8E, 8'h9E});
        m_mw     = (op == 8'hC4) ? 2'b01 : 2'b00;
        m_mm     = op inside {8'hC4, 8'hFB};
        m_cs     = op inside {8'h42, 8'h43};
    endtask

    task automatic check_outputs();
        chk("ctl_valid", 32'(ctl_valid), 32'(m_cv));
        if (m_cv) begin
            chk("instr_out", instr_out, m_instr);
            chk("reg_file_ren", 32'(reg_file_ren), 32'(m_ren));
            chk("reg_file_wen", 32'(reg_file_wen), 32'(m_wen));
            chk("mem_wren", 32'(mem_wren), 32'(m_mw));
            chk("main_memory_enable", 32'(main_memory_enable), 32'(m_mm));
            chk("call_stack_enable", 32'(call_stack_enable), 32'(m_cs));
        end
        chk("stall_fetch", 32'(stall_fetch), 32'((m_mode == M_RET) || (m_mode == M_TRAP)));
        chk("return_in_pipeline", 32'(return_in_pipeline), 32'(m_mode == M_RET));
        chk("halt", 32'(halt), 32'(m_mode == M_HALT));
        chk("illegal_opcode_exception", 32'(illegal_opcode_exception), 32'(m_exc));
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs
    task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic exr,
                         input logic fl, input logic ack, input logic res);
        logic       rdy;
        logic       acc;
        logic       bad;
        logic [7:0] op;
        instr_valid = v;
        instr_in    = ins;
        ex_ready    = exr;
        flush       = fl;
        irq_ack     = ack;
        resume      = res;
        #1;
        op  = ins[7:0];
        rdy = (m_mode == M_RUN) && !fl && (!m_cv || exr);
        chk("decode_ready", 32'(decode_ready), 32'(rdy));
        acc   = v && rdy;
        bad   = TRAP_EN && !is_legal(op);
        m_exc = 1'b0;
        case (m_mode)
            M_RET: begin
                if (fl) m_left = 0;
                else    m_left = m_left - 1;
                if (m_left == 0) m_mode = M_RUN;
            end
            M_HALT: if (res) m_mode = M_RUN;
            M_TRAP: if (ack) m_mode = M_RUN;
            default: begin
                if (acc && bad) begin
                    m_mode = M_TRAP;
                    m_exc  = 1'b1;
                end else if (acc && op == 8'h43) begin
                    m_mode = M_RET;
                    m_left = RSC;
                end else if (acc && op == 8'h1F) begin
                    m_mode = M_HALT;
                end
            end
        endcase
        if (fl)       m_cv = 1'b0;
        else if (acc) m_cv = !bad;
        else if (exr) m_cv = 1'b0;
        if (acc) begin
            m_instr = ins;
            ref_decode(ins);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, ".decode_ready"}, 32'(decode_ready), 32'd0);
        chk({tag, ".ctl_valid"}, 32'(ctl_valid), 32'd0);
        chk({tag, ".instr_out"}, instr_out, 32'd0);
        chk({tag, ".ctrl"}, 32'({reg_file_ren, reg_file_wen, mem_wren, main_memory_enable,
                                 call_stack_enable}), 32'd0);
        chk({tag, ".status"}, 32'({return_in_pipeline, stall_fetch, halt,
                                   illegal_opcode_exception}), 32'd0);
    endtask

    // Assert reset between edges with inputs that would otherwise be accepted
    task automatic do_reset();
        instr_valid = 1'b1;
        instr_in    = 32'h0020_008E;
        ex_ready    = 1'b1;
        flush       = 1'b0;
        irq_ack     = 1'b0;
        resume      = 1'b0;
        rst         = 1'b1;
        #1;
        reset_outputs_zero("rst_now");
        m_mode = M_RUN;
        m_left = 0;
        m_cv   = 1'b0;
        m_exc  = 1'b0;
        @(posedge clk);
        #1;
        reset_outputs_zero("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] ins;
        logic [7:0]    op;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_in    = '0;
        ex_ready    = 1'b0;
        flush       = 1'b0;
        irq_ack     = 1'b0;
        resume      = 1'b0;
        m_instr     = '0;
        ref_decode('0);
        @(posedge clk);
        #1;
        do_reset();

        // Basic accept with one-cycle latency
        cycle(1'b1, 32'h0020_0080, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Backpressure: held word stays, ready low until ex_ready
        cycle(1'b1, 32'h0020_008E, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_00BC, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_00C4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Return stall of RSC cycles
        cycle(1'b1, 32'h0000_0043, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0020_00FB, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Halt, flush while halted, resume
        cycle(1'b1, 32'h0000_001F, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Illegal opcode, then acknowledge
        cycle(1'b1, 32'h0020_00EE, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Flush beats a same-cycle accept
        cycle(1'b1, 32'h0020_009E, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0080, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Flush cuts a return stall short
        cycle(1'b1, 32'h0000_0043, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_00F9, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset in the middle of a return stall with two cycles left
        cycle(1'b1, 32'h0000_0043, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_reset();
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 99) < 85) op = ops[$urandom_range(0, 16)];
            else                            op = 8'($urandom);
            ins[7:0] = op;
            cycle(1'($urandom_range(0, 99) < 70), ins, 1'($urandom_range(0, 99) < 65),
                  1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 25));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width (>= 24).
REQ-002 SHALL have parameter WEN_BIT, default 21, instruction bit that gates register-file writes.
REQ-003 SHALL have parameter RET_STALL_CYCLES, default 3, fetch-stall length after a return (>= 1).
REQ-004 Port: clk  in  1  sole clock; all state on rising edge.
REQ-005 Port: rst  in  1  reset; asynchronous, active-high.
REQ-006 Port: instr_in  in  INSTR_WIDTH  instruction from fetch; opcode = instr_in[7:0].
REQ-007 Port: instr_valid  in  1  instr_in valid.
REQ-008 Port: decode_ready  out  1  block accepts instr_in this cycle; combinational.
REQ-009 Port: ex_ready  in  1  downstream consumes the held control word.
REQ-010 Port: flush, irq_ack, resume  in  1 each  pipeline flush, trap acknowledge, leave halt.
REQ-011 Port: ctl_valid  out  1  control word valid.
REQ-012 Port: instr_out  out  INSTR_WIDTH  registered copy of the accepted instruction.
REQ-013 Port: reg_file_ren, reg_file_wen, mem_wren  out  2 each  registered decode controls.
REQ-014 Port: main_memory_enable, call_stack_enable  out  1 each  registered decode controls.
REQ-015 Port: return_in_pipeline, stall_fetch, halt, illegal_opcode_exception  out  1 each  hazard/interrupt status, registered.

Function
REQ-016 SHALL implement states RUN, RET_WAIT, HALTED, TRAP.
REQ-017 decode_ready SHALL be 1 only in RUN with no flush, and only when ctl_valid=0 or ex_ready=1.
REQ-018 An accept (instr_valid & decode_ready) SHALL load the control word and set ctl_valid on the next edge: latency 1 cycle.
REQ-019 A held control word SHALL remain stable until ex_ready=1; ex_ready with no accept SHALL clear ctl_valid.
REQ-020 reg_file_ren SHALL be 2'b11 for opcodes 80,8E,97; 2'b01 for BC,9E,9B,A5; 2'b00 otherwise.
REQ-021 reg_file_wen[0] SHALL equal instr_in[WEN_BIT] for BC,80,8E,9E,97,9B,A5,FB,F8,F9, else 0. reg_file_wen[1] SHALL equal instr_in[WEN_BIT] for 8E,9E only, else 0.
REQ-022 mem_wren SHALL be 2'b01 and main_memory_enable 1 for C4; main_memory_enable SHALL be 1 for FB; call_stack_enable SHALL be 1 for 42,43.
REQ-023 Legal opcodes: 00,BC,80,8E,9E,97,9B,A5,FB,C4,F8,9C,38,42,43,F9,1F; opcodes 00,38,9C,1F SHALL decode to all-zero controls.
REQ-024 Accepting 43 SHALL enter RET_WAIT and load a down-counter with RET_STALL_CYCLES. While in RET_WAIT: return_in_pipeline=1 and stall_fetch=1. The counter SHALL decrement each cycle; the state SHALL return to RUN on the edge where the counter reaches 0.
REQ-025 Accepting 1F SHALL enter HALTED with halt=1 until resume=1, then RUN on the next edge.
REQ-026 flush SHALL clear ctl_valid on the next edge and discard a same-cycle instruction (flush beats accept). In RET_WAIT, flush SHALL return to RUN with the counter cleared. flush SHALL NOT leave HALTED or TRAP.
REQ-027 Counter width SHALL be $clog2(RET_STALL_CYCLES+1); the counter SHALL NOT wrap below 0.

Reset
REQ-028 rst=1 SHALL immediately force state RUN, counter 0, and every output except decode_ready to 0, including mid-RET_WAIT, HALTED or TRAP.
REQ-029 decode_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.

Configuration
REQ-030 Macro DECODE_ILLEGAL_TRAP_EN SHALL control illegal-opcode handling.
- Defined: accepting an illegal opcode SHALL pulse illegal_opcode_exception for exactly 1 cycle, leave ctl_valid=0, and enter TRAP with stall_fetch=1 until irq_ack=1, then RUN.
- Undefined: an illegal opcode SHALL decode as NOP with ctl_valid=1; illegal_opcode_exception SHALL be tied 0; TRAP SHALL be unreachable.

Verification
REQ-031 instr 0x00200080, valid, ex_ready=1 -> next cycle ctl_valid=1, reg_file_ren=11, reg_file_wen=01.
REQ-032 instr 0x0020008E with ex_ready=0 for 3 cycles -> controls stable (wen=11), decode_ready=0 until ex_ready=1.
REQ-033 instr 0x43, RET_STALL_CYCLES=3 -> stall_fetch=return_in_pipeline=1 for exactly 3 cycles, then decode_ready=1.
REQ-034 instr 0x1F, then resume after 5 cycles -> halt=1 for those cycles, RUN the cycle after resume; flush during HALTED keeps halt=1.
REQ-035 With DECODE_ILLEGAL_TRAP_EN: instr 0xEE -> 1-cycle exception pulse, stall_fetch=1 until irq_ack. Without: ctl_valid=1 with all-zero controls.
REQ-036 rst asserted mid-RET_WAIT (counter=2) -> all outputs 0 immediately; decode_ready=1 the cycle after release.
